// File: rtl/fs_pkg.sv
// Shared types and constants for the formatter-to-USB byte path.
package fs_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t EOL_MARKER = 8'hFF;

  typedef enum logic {
    ACCEPT,
    DROP
  } ingr_st_t;

  function automatic logic is_eol(input byte_t b);
    return b == EOL_MARKER;
  endfunction

endpackage

// File: rtl/usb_line_writer_if.sv
// Byte stream in from the pixel formatter and FT245-style write port out to the USB chip.
interface usb_line_writer_if;
  import fs_pkg::*;

  logic  rx_valid;
  byte_t rx_data;
  logic  usb_txe_n;
  logic  usb_wr_n;
  byte_t usb_data;

  modport slave (
    input  rx_valid,
    input  rx_data,
    input  usb_txe_n,
    output usb_wr_n,
    output usb_data
  );

  modport master (
    output rx_valid,
    output rx_data,
    output usb_txe_n,
    input  usb_wr_n,
    input  usb_data
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port; rd_data updates only on an accepted read.
module sync_fifo
  import fs_pkg::*;
#(
  parameter int unsigned DEPTH = 2048,
  parameter type         T     = byte_t
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     wr_en,
  input  T                         wr_data,
  input  logic                     rd_en,
  output T                         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (count == CAP);
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_data <= '0;
    end else if (rd_ok) begin
      rd_data <= mem[rd_ptr];
    end
  end

endmodule

// File: rtl/usb_line_writer.sv
// Buffers formatter bytes and drains them into the USB FIFO chip, keeping line framing
// intact on overflow and counting end-of-line markers delivered.
module usb_line_writer
  import fs_pkg::*;
#(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   rx_clk,
  input  logic                   nrst,
  usb_line_writer_if.slave       bus,
  input  logic                   clr_ovf,
  output logic                   ovf_sticky,
  output logic [CNT_W-1:0]       lines_sent,
  output logic [$clog2(DEPTH):0] fill_level
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] CAP     = (AW+1)'(DEPTH);
  localparam logic [AW:0] CAP_PIX = CAP - 1'b1;

  ingr_st_t    state_q;
  ingr_st_t    state_d;
  logic        fifo_wr;
  logic        fifo_wr_en;
  logic        fifo_rd;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  byte_t       fifo_rd_data;
  logic        drop;

  logic        pf_valid;
  logic        out_valid;
  byte_t       out_data;
  logic        xfer;
  logic        out_load;

  // Occupancy spans FIFO storage, the prefetch stage and the output register.
  assign fill_level = fifo_count + (AW+1)'(pf_valid) + (AW+1)'(out_valid);

  always_ff @(posedge rx_clk or negedge nrst) begin
    if (!nrst) state_q <= ACCEPT;
    else       state_q <= state_d;
  end

  // One slot is held back for the marker so a truncated line still gets terminated.
  always_comb begin
    state_d = state_q;
    fifo_wr = 1'b0;
    drop    = 1'b0;
    if (bus.rx_valid) begin
      if (is_eol(bus.rx_data)) begin
        fifo_wr = (fill_level < CAP);
        state_d = ACCEPT;
      end else begin
        case (state_q)
          ACCEPT: begin
            if (fill_level < CAP_PIX) begin
              fifo_wr = 1'b1;
            end else begin
              drop    = 1'b1;
              state_d = DROP;
            end
          end
          DROP:    drop = 1'b1;
          default: drop = 1'b1;
        endcase
      end
    end
  end

  assign fifo_wr_en = fifo_wr && !fifo_full;

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (byte_t)
  ) u_fifo (
    .clk     (rx_clk),
    .nrst    (nrst),
    .wr_en   (fifo_wr_en),
    .wr_data (bus.rx_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Prefetch stage (FIFO read register) feeds the output register; both advance together
  // on a transfer so the chip sees one byte per clock while TXE# stays low.
  assign xfer     = out_valid && !bus.usb_txe_n;
  assign out_load = pf_valid && (!out_valid || xfer);
  assign fifo_rd  = !fifo_empty && (!pf_valid || out_load);

  always_ff @(posedge rx_clk or negedge nrst) begin
    if (!nrst) begin
      pf_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (fifo_rd)       pf_valid <= 1'b1;
      else if (out_load) pf_valid <= 1'b0;

      if (out_load) begin
        out_valid <= 1'b1;
        out_data  <= fifo_rd_data;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.usb_wr_n = ~out_valid;
  assign bus.usb_data = out_data;

  always_ff @(posedge rx_clk or negedge nrst) begin
    if (!nrst) begin
      ovf_sticky <= 1'b0;
      lines_sent <= '0;
    end else begin
      if (drop)         ovf_sticky <= 1'b1;
      else if (clr_ovf) ovf_sticky <= 1'b0;

      if (xfer && is_eol(out_data)) lines_sent <= lines_sent + 1'b1;
    end
  end

endmodule

// File: tb/tb_usb_line_writer.sv
// Scoreboard bench for usb_line_writer: accepted bytes are queued at drive time and
// popped as the USB side transfers them.
module tb_usb_line_writer;
  import fs_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 16;

  logic             rx_clk  = 1'b0;
  logic             nrst    = 1'b0;
  logic             clr_ovf = 1'b0;
  logic             ovf_sticky;
  logic [CNT_W-1:0] lines_sent;
  logic [3:0]       fill_level;

  usb_line_writer_if bus ();

  usb_line_writer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .rx_clk     (rx_clk),
    .nrst       (nrst),
    .bus        (bus),
    .clr_ovf    (clr_ovf),
    .ovf_sticky (ovf_sticky),
    .lines_sent (lines_sent),
    .fill_level (fill_level)
  );

  always #5 rx_clk = ~rx_clk;

  int          n_checks  = 0;
  int          n_err     = 0;
  byte_t       sb[$];
  int unsigned lines_exp = 0;
  byte_t       mon_exp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transfer monitor: WR# and TXE# both low ahead of a posedge means a byte leaves on it.
  always begin
    @(negedge rx_clk);
    #2;
    if (nrst === 1'b1 && bus.usb_wr_n === 1'b0 && bus.usb_txe_n === 1'b0) begin
      if (sb.size() == 0) begin
        check_eq("sb_extra_byte", sb.size(), 32'd1);
      end else begin
        mon_exp = sb.pop_front();
        check_eq("usb_data_order", bus.usb_data, mon_exp);
        if (mon_exp == EOL_MARKER) lines_exp++;
      end
    end
  end

  task automatic drive(input logic v, input byte_t d, input logic keep);
    @(negedge rx_clk);
    bus.rx_valid = v;
    bus.rx_data  = d;
    if (v && keep) sb.push_back(d);
  endtask

  task automatic wait_drain(input string tag);
    logic done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge rx_clk);
      #2;
      if (fill_level == 0 && bus.usb_wr_n === 1'b1) done = 1'b1;
    end
    check_eq(tag, done, 1'b1);
    check_eq({tag, "_sb_empty"}, sb.size(), 32'd0);
    check_eq({tag, "_lines_model"}, lines_sent, lines_exp[CNT_W-1:0]);
  endtask

  byte_t t1[4] = '{8'h10, 8'h20, 8'h30, 8'hFF};
  byte_t t2[6] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'hFF};

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_data   = '0;
    bus.usb_txe_n = 1'b0;
    #12;
    check_eq("rst_wr_n", bus.usb_wr_n, 1'b1);
    check_eq("rst_data", bus.usb_data, 8'h00);
    check_eq("rst_fill", fill_level, 4'd0);
    check_eq("rst_ovf", ovf_sticky, 1'b0);
    check_eq("rst_lines", lines_sent, 16'd0);
    @(negedge rx_clk);
    #1 nrst = 1'b1;

    // 1: basic line, latency and back-to-back strobes
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(1'b1, t1[c], 1'b1);
      else       drive(1'b0, 8'h00, 1'b0);
      #2;
      if (c == 2) check_eq("t1_latency_wr_n", bus.usb_wr_n, 1'b1);
      if (c >= 3 && c <= 6) begin
        check_eq("t1_wr_n", bus.usb_wr_n, 1'b0);
        check_eq("t1_data", bus.usb_data, t1[c-3]);
      end
    end
    wait_drain("t1_drain");
    check_eq("t1_lines", lines_sent, 16'd1);

    // 2: TXE# stall mid-line freezes the output register
    for (int c = 0; c < 12; c++) begin
      if (c < 6) drive(1'b1, t2[c], 1'b1);
      else       drive(1'b0, 8'h00, 1'b0);
      bus.usb_txe_n = (c >= 4 && c < 9);
      #2;
      if (c >= 4 && c < 9) begin
        check_eq("t2_stall_wr_n", bus.usb_wr_n, 1'b0);
        check_eq("t2_stall_data", bus.usb_data, 8'h42);
      end
    end
    wait_drain("t2_drain");
    check_eq("t2_lines", lines_sent, 16'd2);

    // 3: overflow truncates the line but keeps its marker
    bus.usb_txe_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, byte_t'(8'h50 + i), i < 7);
      #2;
      if (i == 7) begin
        check_eq("t3_fill_pix_limit", fill_level, 4'd7);
        check_eq("t3_ovf_before_drop", ovf_sticky, 1'b0);
      end
      if (i == 8) check_eq("t3_ovf_after_drop", ovf_sticky, 1'b1);
    end
    drive(1'b1, EOL_MARKER, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    #2;
    check_eq("t3_fill_full", fill_level, 4'd8);
    check_eq("t3_ovf", ovf_sticky, 1'b1);
    check_eq("t3_head_wr_n", bus.usb_wr_n, 1'b0);
    check_eq("t3_head_data", bus.usb_data, 8'h50);
    bus.usb_txe_n = 1'b0;
    wait_drain("t3_drain");
    drive(1'b1, 8'h60, 1'b1);
    drive(1'b1, 8'h61, 1'b1);
    drive(1'b1, 8'h62, 1'b1);
    drive(1'b1, EOL_MARKER, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    wait_drain("t3_next_line");
    check_eq("t3_lines", lines_sent, 16'd4);
    check_eq("t3_ovf_sticky_held", ovf_sticky, 1'b1);

    // 4: set beats clear in the same cycle
    drive(1'b0, 8'h00, 1'b0);
    clr_ovf = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    clr_ovf = 1'b0;
    #2;
    check_eq("t4_clear", ovf_sticky, 1'b0);
    bus.usb_txe_n = 1'b1;
    for (int i = 0; i < 7; i++) drive(1'b1, byte_t'(8'h70 + i), 1'b1);
    drive(1'b1, 8'h77, 1'b0);
    clr_ovf = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    #2;
    check_eq("t4_set_wins", ovf_sticky, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    clr_ovf = 1'b0;
    #2;
    check_eq("t4_clear_next", ovf_sticky, 1'b0);
    drive(1'b1, EOL_MARKER, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    #2;
    check_eq("t4_fill", fill_level, 4'd8);
    bus.usb_txe_n = 1'b0;
    wait_drain("t4_drain");
    check_eq("t4_lines", lines_sent, 16'd5);

    // 6: reset with bytes buffered and a strobe pending
    bus.usb_txe_n = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, byte_t'(8'h90 + i), 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    #2;
    check_eq("t6_pre_wr_n", bus.usb_wr_n, 1'b0);
    check_eq("t6_pre_fill", fill_level, 4'd5);
    @(negedge rx_clk);
    #1 nrst = 1'b0;
    #1;
    check_eq("t6_rst_wr_n", bus.usb_wr_n, 1'b1);
    check_eq("t6_rst_data", bus.usb_data, 8'h00);
    check_eq("t6_rst_fill", fill_level, 4'd0);
    check_eq("t6_rst_lines", lines_sent, 16'd0);
    check_eq("t6_rst_ovf", ovf_sticky, 1'b0);
    sb.delete();
    lines_exp = 0;
    bus.usb_txe_n = 1'b0;
    @(negedge rx_clk);
    #1 nrst = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 1'b0);
    #2;
    check_eq("t6_post_wr_n", bus.usb_wr_n, 1'b1);
    check_eq("t6_post_fill", fill_level, 4'd0);

    // 5: lines_sent wrap
    for (int i = 0; i < 65535; i++) drive(1'b1, EOL_MARKER, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    wait_drain("t5_drain_max");
    check_eq("t5_lines_max", lines_sent, 16'hFFFF);
    drive(1'b1, EOL_MARKER, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    wait_drain("t5_drain_wrap");
    check_eq("t5_lines_wrap", lines_sent, 16'd0);
    drive(1'b1, EOL_MARKER, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    wait_drain("t5_drain_one");
    check_eq("t5_lines_one", lines_sent, 16'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
